// File: rtl/fp_pkg.sv
// Shared FPU definitions: format defaults, canonical encodings, operand classes,
// divider FSM states and flag bit positions.
package fp_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;
  localparam int DEF_BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    ZERO,
    NORMAL,
    INF,
    QNAN_C,
    SNAN_C
  } fp_class_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPECIAL,
    S_DIV,
    S_ROUND,
    S_DONE
  } div_state_t;

  // Bit positions inside the 5-bit flags vector.
  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIV_ZERO  = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic logic is_nan(input fp_class_t c);
    return (c == QNAN_C) || (c == SNAN_C);
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational unpack of one IEEE-754 operand into sign/exponent/fraction and a class.
// Denormals are reported as ZERO so downstream logic flushes them.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic [EXP_W+MAN_W:0] x,
  output logic                 sign,
  output logic [EXP_W-1:0]     expo,
  output logic [MAN_W-1:0]     frac,
  output fp_class_t            cls
);

  assign sign = x[EXP_W+MAN_W];
  assign expo = x[EXP_W+MAN_W-1:MAN_W];
  assign frac = x[MAN_W-1:0];

  always_comb begin
    if (expo == '0) begin
      cls = ZERO;
    end else if (&expo) begin
      if (frac == '0)          cls = INF;
      else if (frac[MAN_W-1])  cls = QNAN_C;
      else                     cls = SNAN_C;
    end else begin
      cls = NORMAL;
    end
  end

endmodule

// File: rtl/fp_divider_seq.sv
// Sequential IEEE-754 divider (a / b): radix-2 restoring mantissa loop, RNE rounding,
// valid/ready on both sides. Define FP_DIV_FLAGS_EN to drive the exception flags.
module fp_divider_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int BIAS  = DEF_BIAS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] quotient,
  output logic [4:0]           flags
);

  localparam int W     = EXP_W + MAN_W + 1;
  localparam int Q_W   = MAN_W + 3;
  localparam int R_W   = MAN_W + 2;
  localparam int CNT_W = $clog2(Q_W + 1);
  localparam int E_W   = EXP_W + 2;

  localparam logic [CNT_W-1:0]      ITERS  = CNT_W'(Q_W);
  localparam logic signed [E_W-1:0] BIAS_S = E_W'(BIAS);
  localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
  localparam logic signed [E_W-1:0] E_ZERO = '0;

  localparam logic [W-1:0] QNAN_W = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  div_state_t state, state_n;

  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  fp_class_t        a_cls, b_cls;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .x(a), .sign(a_sign), .expo(a_exp), .frac(a_frac), .cls(a_cls)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .x(b), .sign(b_sign), .expo(b_exp), .frac(b_frac), .cls(b_cls)
  );

  logic xfer, special_in;
  assign xfer       = in_valid & in_ready;
  assign special_in = (a_cls != NORMAL) || (b_cls != NORMAL);

  // Operand/working registers
  logic             sign_r;
  logic [EXP_W-1:0] ea_r, eb_r;
  fp_class_t        cls_a_r, cls_b_r;
  logic [R_W-1:0]   rem_r;
  logic [MAN_W:0]   dvs_r;
  logic [Q_W-1:0]   q_r;
  logic [CNT_W-1:0] cnt_r;
  logic [W-1:0]     quotient_r;

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state is updated with non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: each always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (xfer) state_n = special_in ? S_SPECIAL : S_DIV;
      S_SPECIAL: state_n = S_DONE;
      S_DIV:     if (cnt_r == CNT_W'(1)) state_n = S_ROUND;
      S_ROUND:   state_n = S_DONE;
      S_DONE:    if (out_ready) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------- Restoring divide step ----------------
  logic [R_W:0]   diff;
  logic           q_bit;
  logic [R_W-1:0] rem_n;

  always_comb begin
    diff  = {1'b0, rem_r} - {2'b00, dvs_r};
    q_bit = ~diff[R_W];
    rem_n = q_bit ? diff[R_W-1:0] : rem_r;
  end

  // NOTE: the working registers carry no reset; they are always loaded on a transfer
  // before the FSM reads them, so reset only has to clear state and visible outputs.
  always_ff @(posedge clk) begin
    if (xfer) begin
      sign_r  <= a_sign ^ b_sign;
      ea_r    <= a_exp;
      eb_r    <= b_exp;
      cls_a_r <= a_cls;
      cls_b_r <= b_cls;
      rem_r   <= {1'b0, 1'b1, a_frac};
      dvs_r   <= {1'b1, b_frac};
      q_r     <= '0;
      cnt_r   <= ITERS;
    end else if (state == S_DIV) begin
      rem_r <= rem_n << 1;
      q_r   <= {q_r[Q_W-2:0], q_bit};
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

  // ---------------- Normalise and round (RNE) ----------------
  logic signed [E_W-1:0] e_diff, e_pre, e_fin;
  logic [MAN_W:0]        mant;
  logic [MAN_W+1:0]      mant_sum;
  logic [MAN_W-1:0]      frac_fin;
  logic                  guard, sticky, inc, carry, ovf, unf;
  logic [W-1:0]          rnd_q;

  always_comb begin
    e_diff = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + BIAS_S;
    if (q_r[Q_W-1]) begin
      mant   = q_r[Q_W-1:2];
      guard  = q_r[1];
      sticky = q_r[0] | (|rem_r);
      e_pre  = e_diff;
    end else begin
      mant   = q_r[Q_W-2:1];
      guard  = q_r[0];
      sticky = |rem_r;
      e_pre  = e_diff - E_ONE;
    end
    inc      = guard & (sticky | mant[0]);
    mant_sum = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
    carry    = mant_sum[MAN_W+1];
    frac_fin = carry ? mant_sum[MAN_W:1] : mant_sum[MAN_W-1:0];
    e_fin    = carry ? e_pre + E_ONE : e_pre;
    ovf      = (e_fin >= E_MAX);
    unf      = (e_fin <= E_ZERO);
    if (ovf)      rnd_q = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (unf) rnd_q = {sign_r, {(W-1){1'b0}}};
    else          rnd_q = {sign_r, e_fin[EXP_W-1:0], frac_fin};
  end

  // ---------------- Special-operand result ----------------
  logic [W-1:0] spec_q;

  always_comb begin
    spec_q = {sign_r, {(W-1){1'b0}}};
    if (is_nan(cls_a_r) || is_nan(cls_b_r)) begin
      spec_q = QNAN_W;
    end else if ((cls_a_r == INF && cls_b_r == INF) || (cls_a_r == ZERO && cls_b_r == ZERO)) begin
      spec_q = QNAN_W;
    end else if (cls_b_r == ZERO || cls_a_r == INF) begin
      // x/0 with x finite nonzero, or inf/finite: both give a signed infinity.
      spec_q = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                     quotient_r <= '0;
    else if (state == S_SPECIAL) quotient_r <= spec_q;
    else if (state == S_ROUND)   quotient_r <= rnd_q;
  end

  assign quotient = quotient_r;

`ifdef FP_DIV_FLAGS_EN
  logic [4:0] spec_f, rnd_f, flags_r;

  always_comb begin
    spec_f = '0;
    if (is_nan(cls_a_r) || is_nan(cls_b_r)) begin
      spec_f[FLAG_INVALID] = (cls_a_r == SNAN_C) || (cls_b_r == SNAN_C);
    end else if ((cls_a_r == INF && cls_b_r == INF) || (cls_a_r == ZERO && cls_b_r == ZERO)) begin
      spec_f[FLAG_INVALID] = 1'b1;
    end else if (cls_b_r == ZERO && cls_a_r == NORMAL) begin
      spec_f[FLAG_DIV_ZERO] = 1'b1;
    end
  end

  always_comb begin
    rnd_f                 = '0;
    rnd_f[FLAG_OVERFLOW]  = ovf;
    rnd_f[FLAG_UNDERFLOW] = unf;
    rnd_f[FLAG_INEXACT]   = ovf | unf | guard | sticky;
  end

  always_ff @(posedge clk) begin
    if (rst)                     flags_r <= '0;
    else if (state == S_SPECIAL) flags_r <= spec_f;
    else if (state == S_ROUND)   flags_r <= rnd_f;
  end

  assign flags = flags_r;
`else
  assign flags = 5'b0;
`endif

endmodule

// File: tb/tb_fp_divider_seq.sv
// Directed self-checking bench for fp_divider_seq: normal/special results, latency,
// backpressure and mid-operation reset. Flag expectations follow FP_DIV_FLAGS_EN.
module tb_fp_divider_seq;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] a, b, quotient;
  logic        out_valid, out_ready;
  logic [4:0]  flags;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [4:0] F_NONE = 5'b0;
  localparam logic [4:0] F_INV  = 5'b1 << FLAG_INVALID;
  localparam logic [4:0] F_DZ   = 5'b1 << FLAG_DIV_ZERO;
  localparam logic [4:0] F_OVF  = 5'b1 << FLAG_OVERFLOW;
  localparam logic [4:0] F_UNF  = 5'b1 << FLAG_UNDERFLOW;
  localparam logic [4:0] F_INX  = 5'b1 << FLAG_INEXACT;

  fp_divider_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, expv);
  endtask

  function automatic logic [4:0] fx(input logic [4:0] f);
`ifdef FP_DIV_FLAGS_EN
    return f;
`else
    return F_NONE & f;
`endif
  endfunction

  // Transfer one operand pair, then count negedges until out_valid (lat = cycles after transfer edge).
  task automatic send(input logic [31:0] a_v, input logic [31:0] b_v, output int lat);
    int guard_cnt = 0;
    @(negedge clk);
    while (!in_ready && guard_cnt < 100) begin
      @(negedge clk);
      guard_cnt++;
    end
    a = a_v;
    b = b_v;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a_v, input logic [31:0] b_v,
                        input logic [31:0] exp_q, input logic [4:0] exp_f, input int exp_lat);
    int lat;
    send(a_v, b_v, lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " quotient"}, quotient, exp_q);
    check({tag, " flags"}, {27'b0, flags}, {27'b0, fx(exp_f)});
    @(negedge clk);
    check({tag, " in_ready after handshake"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset quotient", quotient, 32'h0);
    check("reset flags", {27'b0, flags}, 32'h0);
    rst = 1'b0;

    run_op("6/2",      32'h40C00000, 32'h40000000, 32'h40400000, F_NONE,        28);
    run_op("1/3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAB, F_INX,         28);
    run_op("1/5",      32'h3F800000, 32'h40A00000, 32'h3E4CCCCD, F_INX,         28);
    run_op("1/11",     32'h3F800000, 32'h41300000, 32'h3DBA2E8C, F_INX,         28);
    run_op("5/3",      32'h40A00000, 32'h40400000, 32'h3FD55555, F_INX,         28);
    run_op("-6/2",     32'hC0C00000, 32'h40000000, 32'hC0400000, F_NONE,        28);
    run_op("1/1",      32'h3F800000, 32'h3F800000, 32'h3F800000, F_NONE,        28);
    run_op("ovf",      32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, F_OVF | F_INX, 28);
    run_op("unf",      32'h00800000, 32'h40000000, 32'h00000000, F_UNF | F_INX, 28);
    run_op("-1/0",     32'hBF800000, 32'h00000000, 32'hFF800000, F_DZ,          2);
    run_op("0/0",      32'h00000000, 32'h00000000, QNAN,         F_INV,         2);
    run_op("inf/-inf", 32'h7F800000, 32'hFF800000, QNAN,         F_INV,         2);
    run_op("snan",     32'h7F800001, 32'h3F800000, QNAN,         F_INV,         2);
    run_op("qnan",     32'h7FC00000, 32'h3F800000, QNAN,         F_NONE,        2);
    run_op("-inf/2",   32'hFF800000, 32'h40000000, 32'hFF800000, F_NONE,        2);
    run_op("2/-inf",   32'h40000000, 32'hFF800000, 32'h80000000, F_NONE,        2);
    run_op("inf/0",    POS_INF,      32'h00000000, POS_INF,      F_NONE,        2);
    run_op("den/1",    32'h00000001, 32'h3F800000, 32'h00000000, F_NONE,        2);
    run_op("1/-den",   32'h3F800000, 32'h80000001, 32'hFF800000, F_DZ,          2);

    // Backpressure: result held for 5 cycles while a second operand is offered.
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40400000, lat);
    check("bp latency", lat, 28);
    a = 32'h40C00000;
    b = 32'h40000000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp quotient held", quotient, 32'h3EAAAAAB);
      check("bp flags held", {27'b0, flags}, {27'b0, fx(F_INX)});
      check("bp in_ready low", {31'b0, in_ready}, 32'd0);
      check("bp out_valid held", {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp out_valid drop", {31'b0, out_valid}, 32'd0);
    check("bp in_ready back", {31'b0, in_ready}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("bp single transfer", {31'b0, out_valid}, 32'd0);
    end

    // Reset at DIV iteration 10 aborts the operation.
    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort out_valid", {31'b0, out_valid}, 32'd0);
    check("abort in_ready", {31'b0, in_ready}, 32'd1);
    check("abort quotient", quotient, 32'h0);
    check("abort flags", {27'b0, flags}, 32'h0);
    repeat (30) begin
      @(negedge clk);
      check("abort no output", {31'b0, out_valid}, 32'd0);
    end
    run_op("6/2 after rst", 32'h40C00000, 32'h40000000, 32'h40400000, F_NONE, 28);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_divider_seq.md
Name: fp_divider_seq

Overview:
- Sequential IEEE-754 single-precision divider, quotient = a / b. It is the inverse operation of the combinational fp_multiplier.
- Radix-2 restoring mantissa divider: one quotient bit per cycle, round-to-nearest-even.
- Valid/ready handshakes on input and output, so it sits in the FPU datapath beside fp_multiplier and absorbs downstream backpressure.
- Same number-format policy as fp_multiplier: normal, zero, inf and NaN handled; denormal inputs are treated as zero (flush).

Parameters:
- EXP_W, 8, exponent width
- MAN_W, 23, stored fraction width
- BIAS, 127, exponent bias; must equal 2^(EXP_W-1)-1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands a/b valid
- in_ready  out  1  divider can accept operands
- a  in  EXP_W+MAN_W+1  dividend
- b  in  EXP_W+MAN_W+1  divisor
- out_valid  out  1  quotient valid
- out_ready  in  1  consumer accepts quotient
- quotient  out  EXP_W+MAN_W+1  result
- flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - State goes to IDLE; in_ready=1, out_valid=0, quotient=0, flags=0.
  - An operation in progress is aborted with no output.
- Input handshake: transfer when in_valid & in_ready. in_ready=1 only in IDLE. a and b are captured on the transfer edge.
- FSM IDLE -> SPECIAL | DIV -> ROUND -> DONE -> IDLE.
  - IDLE: on transfer, unpack and classify both operands. If either is special, go to SPECIAL; otherwise go to DIV and load the iteration counter with MAN_W+3.
  - SPECIAL: writes the special result, then goes to DONE. out_valid is high 2 cycles after the transfer edge.
  - DIV: partial remainder starts at {1,frac_a}; divisor is {1,frac_b}. Each cycle: compare/subtract, shift in one quotient bit, decrement the counter. After MAN_W+3 (=26) cycles produce q[25:0], then go to ROUND.
  - ROUND:
    - If q[25]=1: mant=q[25:2], guard=q[1], sticky=q[0]|(rem!=0), e=ea-eb+BIAS.
    - Else: mant=q[24:1], guard=q[0], sticky=(rem!=0), e=ea-eb+BIAS-1.
    - RNE: increment if guard & (sticky | mant[0]). Mantissa carry-out renormalises and sets e+1.
    - e>=255: signed inf, overflow=1, inexact=1. e<=0: signed zero, underflow=1, inexact=1.
    - Then go to DONE.
  - DONE: out_valid=1; quotient and flags are held stable until out_ready=1. On out_valid & out_ready, go to IDLE; in_ready=1 on the next cycle.
- Normal-path latency: out_valid is asserted 28 cycles after the input transfer edge.
- Sign of every non-NaN result = sign_a ^ sign_b.
- Special-case priority:
  1. Either input NaN -> 0x7FC00000 (canonical qNaN); invalid=1 only for sNaN.
  2. inf/inf or 0/0 -> 0x7FC00000, invalid=1.
  3. Finite nonzero / 0 -> signed inf, div_by_zero=1.
  4. inf / finite -> signed inf.
  5. 0 / nonzero, or finite / inf -> signed zero.
- A denormal input is classified as zero before this priority is applied.
- Inputs on a/b while in_ready=0 are ignored. out_ready is ignored unless out_valid=1.

Optional Feature:
- Macro FP_DIV_FLAGS_EN.
- Defined: the flags port is driven as described in Behaviour.
- Undefined: flags is tied to 5'b0 and no flag logic is synthesised. Quotient and timing are identical in both cases.

Decomposition:
- Package fp_pkg: EXP_W/MAN_W/BIAS defaults, QNAN=32'h7FC00000, POS_INF=32'h7F800000, fp_class_t enum {ZERO, NORMAL, INF, QNAN_C, SNAN_C}, flag bit indices.
- Sub-module fp_classify: combinational unpack of sign/exp/frac plus fp_class_t. One instance per operand, and reusable by fp_multiplier.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) -> 0x40400000, flags=0, out_valid exactly 28 cycles after the transfer edge.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB, inexact=1 (checks the RNE round-up).
- 0xBF800000 / 0x00000000 -> 0xFF800000, div_by_zero=1, out_valid 2 cycles after the transfer edge.
- 0x00000000 / 0x00000000 -> 0x7FC00000 invalid=1; 0x7F800000 / 0xFF800000 -> 0x7FC00000 invalid=1.
- 0x7F7FFFFF / 0x3F000000 -> 0x7F800000 overflow=1; 0x00800000 / 0x40000000 -> 0x00000000 underflow=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles: quotient and flags stable, in_ready=0 throughout, one transfer only.
  - Assert rst at DIV iteration 10: next cycle out_valid=0, in_ready=1; the following op 0x40C00000 / 0x40000000 is still correct.
